// File: rtl/pixel_palette_sched.sv
// pixel_palette_sched: per-pixel layer arbiter + zapper flash sequencer, 2-cycle pipe (Clk, Reset, frame_start, trigger, pix_valid, bg/grass/duck_idx, aim_px -> layer_sel, color_idx, out_valid, flash_busy, hit_valid, hit, shot_cnt, hit_cnt); PAL_SCHED_SHOT_STATS_EN enables shot/hit counters
module pixel_palette_sched #(
  parameter int BLACK_FRAMES = 1,
  parameter int TARGET_FRAMES = 1,
  parameter int CNT_W = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       trigger,
  input  logic       pix_valid,
  input  logic [3:0] bg_idx,
  input  logic [3:0] grass_idx,
  input  logic [3:0] duck_idx,
  input  logic       aim_px,
  output logic [1:0] layer_sel,
  output logic [3:0] color_idx,
  output logic       out_valid,
  output logic       flash_busy,
  output logic       hit_valid,
  output logic       hit,
  output logic [7:0] shot_cnt,
  output logic [7:0] hit_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, BLACK, TARGET} state_t;
  localparam logic [CNT_W-1:0] black_init = CNT_W'(BLACK_FRAMES - 1);
  localparam logic [CNT_W-1:0] target_init = CNT_W'(TARGET_FRAMES - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic hit_flag;
  logic [3:0] s1_bg, s1_grass, s1_duck;
  logic s1_aim, s1_valid;
  logic [1:0] nxt_sel;
  logic [3:0] nxt_idx;
  logic flashing, s1_duck_on, seq_end;
  assign flashing = state == BLACK || state == TARGET;
  assign s1_duck_on = s1_duck != 4'd0;
  assign seq_end = state == TARGET && frame_start && cnt == '0;
  assign nxt_sel = flashing ? 2'd3 : s1_duck_on ? 2'd2 : s1_grass != 4'd0 ? 2'd1 : 2'd0;
  assign nxt_idx = state == BLACK ? 4'd0 :
                   state == TARGET ? (s1_duck_on ? 4'd2 : 4'd0) :
                   s1_duck_on ? s1_duck : s1_grass != 4'd0 ? s1_grass : s1_bg;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {s1_bg, s1_grass, s1_duck, s1_aim, s1_valid} <= '0;
      layer_sel <= '0;
      color_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      {s1_bg, s1_grass, s1_duck, s1_aim, s1_valid} <= {bg_idx, grass_idx, duck_idx, aim_px, pix_valid};
      out_valid <= s1_valid;
      if (s1_valid) begin
        layer_sel <= nxt_sel;
        color_idx <= nxt_idx;
      end
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      hit_flag <= 1'b0;
      flash_busy <= 1'b0;
      hit_valid <= 1'b0;
      hit <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      if (state == TARGET && s1_valid && s1_duck_on && s1_aim) hit_flag <= 1'b1;
      case (state)
        IDLE: if (trigger) begin
          state <= frame_start ? BLACK : ARMED;
          cnt <= black_init;
          flash_busy <= frame_start;
        end
        ARMED: if (frame_start) begin
          state <= BLACK;
          cnt <= black_init;
          flash_busy <= 1'b1;
        end
        BLACK: if (frame_start) begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state <= TARGET;
            cnt <= target_init;
            hit_flag <= 1'b0;
          end
        end
        TARGET: if (frame_start) begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state <= IDLE;
            flash_busy <= 1'b0;
            hit_valid <= 1'b1;
            hit <= hit_flag;
            hit_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PAL_SCHED_SHOT_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shot_cnt <= '0;
      hit_cnt <= '0;
    end else begin
      if (state == IDLE && trigger && shot_cnt != 8'hff) shot_cnt <= shot_cnt + 8'd1;
      if (seq_end && hit_flag && hit_cnt != 8'hff) hit_cnt <= hit_cnt + 8'd1;
    end
  end
`else
  assign shot_cnt = 8'd0;
  assign hit_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pixel_palette_sched.sv
// tb_pixel_palette_sched: directed self-checking bench for pixel_palette_sched
module tb_pixel_palette_sched;
  logic Clk = 1'b0, Reset = 1'b1;
  logic frame_start = 0, trigger = 0, pix_valid = 0, aim_px = 0;
  logic [3:0] bg_idx = 0, grass_idx = 0, duck_idx = 0;
  logic [1:0] layer_sel;
  logic [3:0] color_idx;
  logic out_valid, flash_busy, hit_valid, hit;
  logic [7:0] shot_cnt, hit_cnt;
  int tests = 0, fails = 0, hv_cnt = 0, h0;
  pixel_palette_sched dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .trigger(trigger),
    .pix_valid(pix_valid), .bg_idx(bg_idx), .grass_idx(grass_idx), .duck_idx(duck_idx),
    .aim_px(aim_px), .layer_sel(layer_sel), .color_idx(color_idx), .out_valid(out_valid),
    .flash_busy(flash_busy), .hit_valid(hit_valid), .hit(hit),
    .shot_cnt(shot_cnt), .hit_cnt(hit_cnt)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) if (hit_valid) hv_cnt++;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge Clk);
    #1;
  endtask
  task pixel(input logic [3:0] b, input logic [3:0] g, input logic [3:0] d, input logic a);
    bg_idx = b; grass_idx = g; duck_idx = d; aim_px = a; pix_valid = 1;
    tick;
    pix_valid = 0; aim_px = 0;
    tick;
  endtask
  task fs;
    frame_start = 1;
    tick;
    frame_start = 0;
  endtask
  task trig(input logic with_fs);
    trigger = 1; frame_start = with_fs;
    tick;
    trigger = 0; frame_start = 0;
  endtask
  task out_chk(input string tag, input logic [1:0] s, input logic [3:0] i);
    chk({tag, "_sel"}, layer_sel, s);
    chk({tag, "_idx"}, color_idx, i);
  endtask
  initial begin
    tick; tick;
    chk("rst_out", {layer_sel, color_idx, out_valid, flash_busy, hit_valid, hit}, 0);
    chk("rst_cnt", {shot_cnt, hit_cnt}, 0);
    Reset = 0;
    tick;
    pixel(3, 4, 0, 0); out_chk("pri_grass", 1, 4); chk("pri_ov", out_valid, 1);
    tick; chk("hold_ov", out_valid, 0); out_chk("hold", 1, 4);
    pixel(3, 4, 7, 0); out_chk("pri_duck", 2, 7);
    pixel(3, 0, 0, 0); out_chk("pri_bg", 0, 3);
    trig(0); chk("armed_busy", flash_busy, 0);
    fs; chk("black_busy", flash_busy, 1);
    pixel(3, 4, 5, 0); out_chk("black", 3, 0);
    fs; chk("target_busy", flash_busy, 1);
    pixel(3, 4, 5, 1); out_chk("tgt_duck", 3, 2);
    pixel(3, 4, 0, 0); out_chk("tgt_bg", 3, 0);
    fs; chk("end_hv", hit_valid, 1); chk("end_hit", hit, 1); chk("end_busy", flash_busy, 0);
    tick; chk("post_hv", hit_valid, 0); chk("post_hit_hold", hit, 1);
    pixel(3, 4, 7, 0); out_chk("post_norm", 2, 7);
    h0 = hv_cnt;
    trig(1); chk("simul_busy", flash_busy, 1);
    trig(0);
    fs;
    pixel(3, 4, 0, 1); out_chk("miss_bg", 3, 0);
    pixel(3, 4, 5, 0); out_chk("miss_duck", 3, 2);
    fs; chk("miss_hv", hit_valid, 1); chk("miss_hit", hit, 0);
    repeat (3) tick;
    chk("one_pulse", hv_cnt - h0, 1);
    trig(1); fs;
    pixel(3, 4, 5, 1); out_chk("rst_tgt", 3, 2);
    h0 = hv_cnt;
    Reset = 1;
    #1;
    chk("mid_rst_out", {layer_sel, color_idx, flash_busy, hit_valid, hit}, 0);
    tick;
    Reset = 0;
    fs; fs; tick;
    chk("mid_rst_nohv", hv_cnt - h0, 0);
    chk("mid_rst_busy", flash_busy, 0);
    pixel(3, 0, 6, 0); out_chk("mid_rst_norm", 2, 6);
`ifdef PAL_SCHED_SHOT_STATS_EN
    Reset = 1; tick; Reset = 0; tick;
    for (int k = 0; k < 3; k++) begin
      trig(1); fs;
      pixel(0, 0, 5, k != 2);
      fs;
    end
    chk("shot3", shot_cnt, 3); chk("hit2", hit_cnt, 2);
    for (int k = 0; k < 300; k++) begin
      trig(1); fs; fs;
    end
    chk("shot_sat", shot_cnt, 255); chk("hit_keep", hit_cnt, 2);
`else
    chk("stats_off", {shot_cnt, hit_cnt}, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pixel_palette_sched.md
Name: pixel_palette_sched

Overview:
- Per-pixel layer arbiter and flash sequencer in front of the palette lookups (background, grass, duck).
- Each pixel, it picks the highest-priority non-transparent layer and emits that layer's select and 4-bit colour index.
- On a zapper trigger it runs the frame-based flash sequence: a black frame, then a target frame where ducks are white.
- During the target frame it reports whether the aimed pixel landed on a duck.

Parameters:
- BLACK_FRAMES, 1, number of all-black frames after a trigger (>=1).
- TARGET_FRAMES, 1, number of target frames, duck pixels white (>=1).
- CNT_W, 4, width of the frame down-counter; must hold max(BLACK_FRAMES,TARGET_FRAMES)-1.

Ports:
- Clk  in  1  pixel clock; single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse, start of vertical blanking.
- trigger  in  1  one-cycle zapper pull pulse.
- pix_valid  in  1  input pixel indices valid this cycle.
- bg_idx  in  4  background layer colour index.
- grass_idx  in  4  grass layer colour index; 0 = transparent.
- duck_idx  in  4  duck layer colour index; 0 = transparent.
- aim_px  in  1  current pixel lies under the light-sensor window.
- layer_sel  out  2  0=bg, 1=grass, 2=duck, 3=fixed (grass palette used, idx 0 black / idx 2 white).
- color_idx  out  4  index to the selected palette.
- out_valid  out  1  layer_sel/color_idx valid.
- flash_busy  out  1  high in BLACK or TARGET.
- hit_valid  out  1  one-cycle pulse at the end of a flash sequence.
- hit  out  1  result, valid with hit_valid.
- shot_cnt  out  8  see Optional Feature.
- hit_cnt  out  8  see Optional Feature.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, hit_flag 0, pipeline valids 0. Reset mid-flash aborts the sequence with no hit_valid.
- Pipeline: 2 stages, fixed latency 2.
  - Stage 1 registers the indices, aim_px and pix_valid.
  - Stage 2 computes and registers the outputs.
  - out_valid = pix_valid delayed 2 cycles.
  - When out_valid is 0, layer_sel and color_idx hold their previous values.
- Normal priority (IDLE):
  - duck_idx!=0 -> layer 2, duck_idx.
  - else grass_idx!=0 -> layer 1, grass_idx.
  - else layer 0, bg_idx.
- BLACK state: every valid pixel -> layer 3, idx 0.
- TARGET state: duck_idx!=0 -> layer 3, idx 2; else layer 3, idx 0.
- Override uses the FSM state current at the stage-2 cycle.
- FSM (IDLE, ARMED, BLACK, TARGET):
  - IDLE: trigger -> ARMED. If trigger and frame_start arrive in the same cycle -> BLACK directly, cnt=BLACK_FRAMES-1.
  - ARMED: frame_start -> BLACK, cnt=BLACK_FRAMES-1.
  - BLACK: frame_start with cnt!=0 -> cnt-1. frame_start with cnt==0 -> TARGET, cnt=TARGET_FRAMES-1, hit_flag cleared.
  - TARGET: frame_start with cnt!=0 -> cnt-1. frame_start with cnt==0 -> IDLE, and in the same cycle hit_valid=1, hit=hit_flag (hit_flag sampled before clearing), then hit_flag cleared.
  - trigger in ARMED/BLACK/TARGET is ignored.
- hit_flag: set in TARGET when a stage-2 pixel is valid with duck_idx!=0 and aim_px=1; sticky until sequence end.
- flash_busy = (state==BLACK || state==TARGET). It is registered and tracks the state.
- hit stays at its last value between pulses.

Optional Feature:
- Macro PAL_SCHED_SHOT_STATS_EN.
- Defined:
  - shot_cnt increments on each accepted trigger (IDLE->ARMED or IDLE->BLACK).
  - hit_cnt increments on each hit_valid with hit=1.
  - Both are 8-bit, saturate at 255, and reset to 0.
- Undefined: shot_cnt and hit_cnt tied to 0; no counter logic.

Test Plan:
- Priority: pix_valid=1, bg=3, grass=4, duck=0 -> 2 cycles later layer_sel=1, color_idx=4, out_valid=1. With duck=7 -> layer_sel=2, color_idx=7. With grass=0, duck=0 -> layer_sel=0, color_idx=3.
- Flash sequence, BLACK_FRAMES=1, TARGET_FRAMES=1:
  - trigger, then frame_start -> frame 1: all pixels layer 3 idx 0, flash_busy=1.
  - Next frame_start -> frame 2: duck=5 pixels give idx 2, others idx 0.
  - Next frame_start -> hit_valid pulse, state IDLE, normal output.
- Hit detect: in TARGET, one pixel with duck=5 and aim_px=1 -> hit=1 at sequence end. Repeat with aim_px only on duck=0 pixels -> hit=0.
- Simultaneous and ignored triggers:
  - trigger and frame_start in the same cycle from IDLE -> BLACK immediately.
  - A second trigger during BLACK -> no effect; exactly one hit_valid.
- Reset mid-TARGET: assert Reset -> all outputs 0 at once, no hit_valid. After release, IDLE with normal priority output.
- With PAL_SCHED_SHOT_STATS_EN defined, run 3 sequences with 2 hits -> shot_cnt=3, hit_cnt=2. Run 300 sequences -> shot_cnt=255 (saturated).
